// File: rtl/router_inj_pkg.sv
// Shared definitions for the router injection scheduler.
//   state_t          : arbitration state (free port / packet owns the port)
//   DEF_*            : default block parameters
//   VC_IDX_W         : VC index width for the default VC count
//   FC_VALID_BIT     : flow-control bus bit carrying the credit-return strobe
//   FC_VC_LSB        : lowest bit of the returned VC index on the flow-control bus
//   CREDITS_PER_VC   : downstream buffer slots owned by each VC after reset
//   wrap_inc()       : modulo increment used for the round-robin pointer
package router_inj_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_NUM_VCS       = 4;
    localparam int DEF_CHANNEL_WIDTH = 340;
    localparam int DEF_FC_WIDTH      = 10;
    localparam int DEF_BUFFER_SIZE   = 64;

    localparam int VC_IDX_W       = $clog2(DEF_NUM_VCS);
    localparam int FC_VALID_BIT   = 0;
    localparam int FC_VC_LSB      = 1;
    localparam int CREDITS_PER_VC = DEF_BUFFER_SIZE / DEF_NUM_VCS;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/router_inj_sched_rr_arbiter.sv
// Round-robin arbiter: the requester at i_ptr has highest priority, then
// i_ptr+1, and so on with wrap-around.
//   i_req       : request vector
//   i_ptr       : index of the highest-priority requester
//   o_grant     : one-hot grant (all zero when nothing requests)
//   o_grant_idx : binary index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0] w_sum;
    logic           w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        for (int off = 0; off < N; off++) begin
            // one extra bit so the wrap also works for non power-of-two N
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(off);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            if (!w_found && i_req[w_sum[IDX_W-1:0]]) begin
                o_grant[w_sum[IDX_W-1:0]] = 1'b1;
                o_grant_idx               = w_sum[IDX_W-1:0];
                w_found                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_inj_sched.sv
// Injection-side scheduler: shares the router input channel among NUM_REQ
// local sources with round-robin arbitration and wormhole locking, and only
// launches a flit when its VC holds a downstream credit.
//   clk               : clock
//   reset             : asynchronous active-low reset
//   req_valid/vc/tail : per-requester flit handshake and attributes
//   req_flit          : per-requester payload, requester i at [i*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//   req_ready         : combinational accept (valid & ready = flit taken)
//   flow_ctrl_in      : credit return bus (valid bit + VC index)
//   channel_out*      : registered flit, valid and VC towards the router
//   error             : sticky credit overflow/underflow flag
//
// state     | meaning
// ST_IDLE   | no packet owns the port; round-robin among eligible sources
// ST_LOCKED | r_owner is mid-packet; only it may send, on r_owner_vc
import router_inj_pkg::*;

module router_inj_sched #(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int NUM_VCS       = DEF_NUM_VCS,
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int FC_WIDTH      = DEF_FC_WIDTH,
    parameter int BUFFER_SIZE   = DEF_BUFFER_SIZE
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*$clog2(NUM_VCS)-1:0]  req_vc,
    input  logic [NUM_REQ-1:0]                  req_tail,
    input  logic [NUM_REQ*CHANNEL_WIDTH-1:0]    req_flit,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [FC_WIDTH-1:0]                 flow_ctrl_in,
    output logic [CHANNEL_WIDTH-1:0]            channel_out,
    output logic                                channel_out_valid,
    output logic [$clog2(NUM_VCS)-1:0]          channel_out_vc,
    output logic                                error
);

    localparam int VC_W     = $clog2(NUM_VCS);
    localparam int REQ_W    = $clog2(NUM_REQ);
    localparam int CRED_MAX = BUFFER_SIZE / NUM_VCS;
    localparam int CRED_W   = $clog2(CRED_MAX) + 1;
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CRED_MAX);

    state_t                   r_state;
    logic [REQ_W-1:0]         r_owner;
    logic [VC_W-1:0]          r_owner_vc;
    logic [REQ_W-1:0]         r_rr_ptr;
    logic [CRED_W-1:0]        r_credit [NUM_VCS];
    logic                     r_error;
    logic [CHANNEL_WIDTH-1:0] r_chan;
    logic                     r_chan_valid;
    logic [VC_W-1:0]          r_chan_vc;

    logic [VC_W-1:0]          w_req_vc [NUM_REQ];
    logic [NUM_REQ-1:0]       w_elig;
    logic [NUM_REQ-1:0]       w_grant;
    logic [REQ_W-1:0]         w_grant_idx;
    logic [NUM_REQ-1:0]       w_ready;
    logic [REQ_W-1:0]         w_sel_idx;
    logic [VC_W-1:0]          w_send_vc;
    logic                     w_send;
    logic                     w_send_tail;
    logic [CHANNEL_WIDTH-1:0] w_send_flit;
    logic                     w_fc_valid;
    logic [VC_W-1:0]          w_fc_vc;
    logic [NUM_VCS-1:0]       w_inc;
    logic [NUM_VCS-1:0]       w_dec;
    logic                     w_unused_fc;

    assign w_fc_valid  = flow_ctrl_in[FC_VALID_BIT];
    assign w_fc_vc     = flow_ctrl_in[FC_VC_LSB +: VC_W];
    assign w_unused_fc = &{1'b0, flow_ctrl_in};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_vc[i] = req_vc[i*VC_W +: VC_W];
            w_elig[i]   = req_valid[i] && (r_credit[w_req_vc[i]] != '0);
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .i_req       (w_elig),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // While locked, body flits travel on the VC sampled at the head, so the
    // owner's eligibility is judged on that VC, not on its current req_vc.
    always_comb begin
        w_ready   = '0;
        w_sel_idx = w_grant_idx;
        w_send_vc = w_req_vc[w_grant_idx];
        if (r_state == ST_LOCKED) begin
            w_sel_idx          = r_owner;
            w_send_vc          = r_owner_vc;
            w_ready[r_owner]   = req_valid[r_owner] && (r_credit[r_owner_vc] != '0);
        end else begin
            w_ready = w_grant;
        end
        if (!reset) begin
            w_ready = '0;
        end
    end

    assign req_ready   = w_ready;
    assign w_send      = |w_ready;
    assign w_send_tail = req_tail[w_sel_idx];
    assign w_send_flit = req_flit[w_sel_idx*CHANNEL_WIDTH +: CHANNEL_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_owner_vc   <= '0;
            r_rr_ptr     <= '0;
            r_chan       <= '0;
            r_chan_valid <= 1'b0;
            r_chan_vc    <= '0;
        end else begin
            r_chan_valid <= w_send;
            if (w_send) begin
                r_chan    <= w_send_flit;
                r_chan_vc <= w_send_vc;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_send) begin
                        if (w_send_tail) begin
                            r_rr_ptr <= REQ_W'(wrap_inc(int'(w_sel_idx), NUM_REQ));
                        end else begin
                            r_state    <= ST_LOCKED;
                            r_owner    <= w_sel_idx;
                            r_owner_vc <= w_send_vc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_send && w_send_tail) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= REQ_W'(wrap_inc(int'(r_owner), NUM_REQ));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            w_inc[v] = w_fc_valid && (w_fc_vc == VC_W'(v));
            w_dec[v] = w_send && (w_send_vc == VC_W'(v));
        end
    end

    // A send and a return on the same VC in one cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_credit[v] <= CRED_FULL;
            end
            r_error <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_inc[v] && !w_dec[v]) begin
                    if (r_credit[v] == CRED_FULL) begin
                        r_error <= 1'b1;
                    end else begin
                        r_credit[v] <= r_credit[v] + 1'b1;
                    end
                end else if (w_dec[v] && !w_inc[v]) begin
                    if (r_credit[v] == '0) begin
                        r_error <= 1'b1;
                    end else begin
                        r_credit[v] <= r_credit[v] - 1'b1;
                    end
                end
            end
        end
    end

    assign channel_out       = r_chan;
    assign channel_out_valid = r_chan_valid;
    assign channel_out_vc    = r_chan_vc;
    assign error             = r_error;

endmodule

// File: tb/tb_router_inj_sched.sv
module tb_router_inj_sched;

    localparam int NR = 4;
    localparam int CW = 340;
    localparam int CREDITS = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [2*NR-1:0] req_vc = '0;
    logic [NR-1:0]   req_tail = '0;
    logic [NR*CW-1:0] req_flit = '0;
    logic [NR-1:0]   req_ready;
    logic [9:0]      flow_ctrl_in = '0;
    logic [CW-1:0]   channel_out;
    logic            channel_out_valid;
    logic [1:0]      channel_out_vc;
    logic            error;

    router_inj_sched dut (
        .clk               (clk),
        .reset             (reset_n),
        .req_valid         (req_valid),
        .req_vc            (req_vc),
        .req_tail          (req_tail),
        .req_flit          (req_flit),
        .req_ready         (req_ready),
        .flow_ctrl_in      (flow_ctrl_in),
        .channel_out       (channel_out),
        .channel_out_valid (channel_out_valid),
        .channel_out_vc    (channel_out_vc),
        .error             (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_flit(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_cred [4];
    bit   m_locked;
    int   m_owner, m_owner_vc, m_rr;
    bit   m_err;
    bit   m_exp_valid;
    int   m_exp_vc;
    logic [CW-1:0] m_exp_flit;

    task automatic model_reset();
        for (int v = 0; v < 4; v++) m_cred[v] = CREDITS;
        m_locked = 0; m_owner = 0; m_owner_vc = 0; m_rr = 0; m_err = 0;
        m_exp_valid = 0; m_exp_vc = 0; m_exp_flit = '0;
    endtask

    function automatic int vc_of(input int i);
        logic [2*NR-1:0] t;
        t = req_vc;
        return int'(t[2*i +: 2]);
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        r = '0;
        if (m_locked) begin
            if (req_valid[m_owner] && m_cred[m_owner_vc] > 0) r[m_owner] = 1'b1;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_rr + k) % NR;
                if (r == 0 && req_valid[i] && m_cred[vc_of(i)] > 0) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_apply(input logic [3:0] r);
        int idx, svc;
        idx = -1; svc = -1;
        for (int i = 0; i < NR; i++) if (r[i]) idx = i;
        m_exp_valid = (idx >= 0);
        if (idx >= 0) begin
            svc = m_locked ? m_owner_vc : vc_of(idx);
            m_exp_vc = svc;
            m_exp_flit = req_flit[idx*CW +: CW];
            if (!m_locked) begin
                if (!req_tail[idx]) begin
                    m_locked = 1; m_owner = idx; m_owner_vc = svc;
                end else m_rr = (idx + 1) % NR;
            end else if (req_tail[idx]) begin
                m_locked = 0; m_rr = (idx + 1) % NR;
            end
        end
        for (int v = 0; v < 4; v++) begin
            bit inc, dec;
            inc = flow_ctrl_in[0] && (int'(flow_ctrl_in[2:1]) == v);
            dec = (svc == v);
            if (inc && !dec) begin
                if (m_cred[v] == CREDITS) m_err = 1; else m_cred[v]++;
            end else if (dec && !inc) begin
                if (m_cred[v] == 0) m_err = 1; else m_cred[v]--;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0; req_tail = '0; req_vc = '0; flow_ctrl_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic [3:0] exp_rdy);
        @(negedge clk);
        chk(nm, 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_flits();
        logic [351:0] t;
        for (int i = 0; i < NR; i++) begin
            for (int w = 0; w < 11; w++) t[w*32 +: 32] = $urandom;
            req_flit[i*CW +: CW] = t[CW-1:0];
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [7:0] vc;
        logic [3:0] tail;
        logic [9:0] fc;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ovc;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] v, input logic [7:0] vc,
                       input logic [3:0] tail, input logic [9:0] fc, input logic [3:0] rdy,
                       input logic ov, input logic [1:0] ovc, input logic err);
        vec_t e;
        e = '{rst, v, vc, tail, fc, rdy, ov, ovc, err};
        tbl.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] er;

        // reset state, with requests pending during reset
        req_valid = 4'hF; req_tail = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_ov", 64'(channel_out_valid), 64'h0);
        chk("rst_vc", 64'(channel_out_vc), 64'h0);
        chk("rst_err", 64'(error), 64'h0);
        chk_flit("rst_flit", channel_out, '0);
        for (int i = 0; i < NR; i++) req_flit[i*CW +: CW] = {85{4'(i + 1)}};

        // rst, v, vc, tail, fc, ready, out_valid, out_vc, err
        add(1, 4'b0001, 8'h00, 4'b0000, 10'h0, 4'b0001, 1, 2'd0, 0);
        add(0, 4'b0001, 8'h00, 4'b0000, 10'h0, 4'b0001, 1, 2'd0, 0);
        add(0, 4'b0001, 8'h00, 4'b0001, 10'h0, 4'b0001, 1, 2'd0, 0);
        add(0, 4'b0000, 8'h00, 4'b0000, 10'h0, 4'b0000, 0, 2'd0, 0);
        add(1, 4'b1111, 8'hE4, 4'b1111, 10'h0, 4'b0001, 1, 2'd0, 0);
        add(0, 4'b1111, 8'hE4, 4'b1111, 10'h0, 4'b0010, 1, 2'd1, 0);
        add(0, 4'b1111, 8'hE4, 4'b1111, 10'h0, 4'b0100, 1, 2'd2, 0);
        add(0, 4'b1111, 8'hE4, 4'b1111, 10'h0, 4'b1000, 1, 2'd3, 0);
        add(0, 4'b1111, 8'hE4, 4'b1111, 10'h0, 4'b0001, 1, 2'd0, 0);
        add(0, 4'b0010, 8'hE4, 4'b0000, 10'h0, 4'b0010, 1, 2'd1, 0);
        add(0, 4'b0110, 8'hEC, 4'b0000, 10'h0, 4'b0010, 1, 2'd1, 0);
        add(0, 4'b0100, 8'hE4, 4'b0000, 10'h0, 4'b0000, 0, 2'd0, 0);
        add(0, 4'b0110, 8'hE4, 4'b0010, 10'h0, 4'b0010, 1, 2'd1, 0);
        add(0, 4'b0100, 8'hE4, 4'b0100, 10'h0, 4'b0100, 1, 2'd2, 0);

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            req_valid = tbl[k].v; req_vc = tbl[k].vc; req_tail = tbl[k].tail;
            flow_ctrl_in = tbl[k].fc;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", k), 64'(req_ready), 64'(tbl[k].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_ov", k), 64'(channel_out_valid), 64'(tbl[k].ov));
            if (tbl[k].ov) chk($sformatf("tbl%0d_vc", k), 64'(channel_out_vc), 64'(tbl[k].ovc));
            chk($sformatf("tbl%0d_err", k), 64'(error), 64'(tbl[k].err));
        end

        // credit exhaustion on VC 2, return at t usable at t+1
        do_reset();
        req_valid = 4'b0100; req_vc = 8'h20; req_tail = 4'b0100;
        for (int k = 0; k < 16; k++) step("drain", 4'b0100);
        step("stall17", 4'b0000);
        flow_ctrl_in = 10'b101;
        step("ret_cycle", 4'b0000);
        flow_ctrl_in = 10'b0;
        step("after_ret", 4'b0100);
        // send plus return on the same VC leaves the counter unchanged
        flow_ctrl_in = 10'b101;
        step("pre_ret", 4'b0000);
        step("send_and_ret", 4'b0100);
        flow_ctrl_in = 10'b0;
        step("send_after", 4'b0100);
        step("empty_again", 4'b0000);
        chk("drain_err", 64'(error), 64'h0);

        // overflow: return on a full VC sets sticky error, counter saturates
        do_reset();
        flow_ctrl_in = 10'b001;
        step("ret_full", 4'b0000);
        flow_ctrl_in = 10'b0;
        chk("err_set", 64'(error), 64'h1);
        repeat (3) step("idle", 4'b0000);
        chk("err_sticky", 64'(error), 64'h1);
        req_valid = 4'b0001; req_vc = 8'h00; req_tail = 4'b0001;
        for (int k = 0; k < 16; k++) step("sat_send", 4'b0001);
        step("sat_stall", 4'b0000);
        do_reset();
        chk("err_cleared", 64'(error), 64'h0);

        // reset asserted while a packet holds the port
        req_valid = 4'b0001; req_vc = 8'h00; req_tail = 4'b0000;
        step("lk_head", 4'b0001);
        step("lk_body", 4'b0001);
        chk("lk_ov_before", 64'(channel_out_valid), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("lk_ov_rst", 64'(channel_out_valid), 64'h0);
        chk_flit("lk_flit_rst", channel_out, '0);
        chk("lk_ready_rst", 64'(req_ready), 64'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 4'b1111; req_vc = 8'hE4; req_tail = 4'b1111;
        step("post_rst_rr0", 4'b0001);

        // randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid = 4'($urandom);
            req_vc = 8'($urandom);
            req_tail = 4'($urandom);
            rand_flits();
            flow_ctrl_in = {7'($urandom), 2'($urandom),
                            ($urandom_range(0, 7) < ((c < 1500) ? 1 : 4)) ? 1'b1 : 1'b0};
            @(negedge clk);
            er = model_ready();
            chk("rnd_ready", 64'(req_ready), 64'(er));
            @(posedge clk);
            #1;
            model_apply(er);
            chk("rnd_ov", 64'(channel_out_valid), 64'(m_exp_valid));
            if (m_exp_valid) begin
                chk("rnd_vc", 64'(channel_out_vc), 64'(m_exp_vc));
                chk_flit("rnd_flit", channel_out, m_exp_flit);
            end
            chk("rnd_err", 64'(error), 64'(m_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_inj_sched.md
# router_inj_sched

Injection-side scheduler for a router slice. Shares the router's single 340-bit input channel among NUM_REQ local requesters using round-robin arbitration and wormhole packet locking. Tracks per-VC downstream credits returned over the router flow-control bus, and launches a flit only when its VC has a credit. Sits between the tile's injection sources and router channel_in_ip.

## Interface
Parameters:
- NUM_REQ, 4, number of injection requesters
- NUM_VCS, 4, virtual channels (power of two)
- CHANNEL_WIDTH, 340, flit/channel width
- FC_WIDTH, 10, flow-control bus width
- BUFFER_SIZE, 64, total downstream buffer slots; per-VC credits = BUFFER_SIZE/NUM_VCS (16)

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock, asynchronous and active-low
- req_valid  in  NUM_REQ  requester i has a flit
- req_vc  in  NUM_REQ*log2(NUM_VCS)  VC of requester i's flit
- req_tail  in  NUM_REQ  flit is last of packet
- req_flit  in  NUM_REQ*CHANNEL_WIDTH  flit payload
- req_ready  out  NUM_REQ  flit accepted this cycle when valid&ready
- flow_ctrl_in  in  FC_WIDTH  credit return: bit 0 valid, bits 1..log2(NUM_VCS) VC index, rest ignored
- channel_out  out  CHANNEL_WIDTH  flit to router channel_in_ip
- channel_out_valid  out  1  channel_out holds a valid flit
- channel_out_vc  out  log2(NUM_VCS)  VC of channel_out
- error  out  1  sticky credit over/underflow flag

## Operation
- FSM states: IDLE (no packet owns the port) and LOCKED (owner index held).
- Eligibility of requester i: req_valid[i] and credit[req_vc[i]] > 0.
- IDLE: round-robin pick among eligible requesters, starting at rr_ptr. Winner gets req_ready. If the winner's flit is not tail → LOCKED(owner=winner). If it is tail (single-flit packet) → stay IDLE. Either way rr_ptr ← winner+1 mod NUM_REQ, updated when the packet's tail is accepted.
- LOCKED: only the owner can be ready, and only if it is eligible. Other requesters are ignored. Owner's tail accepted → IDLE, rr_ptr ← owner+1.
- Owner VC is sampled at head and used for all flits of the packet. req_vc on body flits is ignored.
- Credits: one counter per VC, width log2(BUFFER_SIZE/NUM_VCS)+1.
  - Flit sent: decrement.
  - Credit return (flow_ctrl_in[0]): increment the indexed VC.
  - Both on the same VC in the same cycle: unchanged.
- Increment at maximum: saturate and set error. Decrement at zero cannot occur by construction; if it does, set error. error clears only on reset.
- No eligible requester: all req_ready=0, channel_out_valid=0 next cycle.
- Locked owner without credit, or owner deasserting valid: stall. The lock is held and no other requester is granted.

## Timing
- Reset (async assert, sync release): IDLE, rr_ptr=0, all credits=BUFFER_SIZE/NUM_VCS, channel_out=0, channel_out_valid=0, channel_out_vc=0, error=0, req_ready=0.
- req_ready is combinational from state, credits, req_valid and req_vc. It never depends on channel_out.
- Accept at cycle t → channel_out/valid/vc registered at t+1 (latency 1). Throughput is one flit per cycle.
- Credit decrement is visible at t+1. With 1 credit left, back-to-back sends on that VC are blocked at t+1.
- Credit returned at t is usable for eligibility at t+1.
- Reset asserted mid-packet: lock dropped, in-flight output cleared immediately. The partial packet is the source's responsibility.

## Structure
- Shared package router_inj_pkg:
  - state enum {IDLE, LOCKED}
  - VC index width
  - flow_ctrl bit positions (FC_VALID_BIT=0, FC_VC_LSB=1)
  - default per-VC credit constant
- Sub-module rr_arbiter: NUM_REQ-wide, with request vector, pointer, one-hot grant and grant index. Priority rotates from the pointer.
- Credit counters, FSM and output register live in the top module.

## Test plan
- Reset, then req_valid=4'b0001, vc 0, 3-flit packet → req_ready[0] on 3 consecutive cycles; channel_out_valid 1 cycle later each; credit[0] ends at 13.
- req_valid=4'b1111, all single-flit packets, rr_ptr=0 → grants in order 0,1,2,3,0 on consecutive cycles.
- Requester 1 locked mid-packet, requester 2 valid → requester 2 is not granted until requester 1's tail; then requester 2 wins.
- 16 flits on VC 2 with no returns → 17th stalls (ready=0). A credit return on VC 2 at cycle t → flit accepted at t+1.
- Send plus credit return on the same VC in the same cycle → counter unchanged. Credit return with counter at 16 → error=1, sticky until reset.
- Reset asserted during LOCKED → channel_out_valid=0 immediately. After release, rr_ptr=0 and credits are all 16.
